// File: rtl/rf_writeback_arbiter.sv
// rf_writeback_arbiter
//   Collects completed results from the ALU, FPU and load unit and serialises
//   them onto the single register-file write port, one write per cycle.
//   Each producer feeds a DEPTH-entry FIFO. A fixed-priority arbiter
//   (mem > fpu > alu) drains the FIFOs. A source that has lost arbitration
//   STARVE_LIMIT times in a row becomes urgent and beats non-urgent sources.
//
// Ports
//   clk, rstn                   clock (rising edge), async active-low reset
//   {alu,fpu,mem}_valid/_ready  per-producer handshake (transfer on valid & ready)
//   {alu,fpu,mem}_fmode/_reg/_data  destination file, register, result
//   wenable/wfmode/wreg/wdata   registered register-file write port
//   chk_fmode/chk_reg           pending-write query from issue
//   chk_pending                 query hits a buffered or outgoing write (combinational)
//   idle                        all FIFOs empty and no write on the port
module rf_writeback_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic        alu_fmode,
  input  logic [4:0]  alu_reg,
  input  logic [31:0] alu_data,
  input  logic        fpu_valid,
  output logic        fpu_ready,
  input  logic        fpu_fmode,
  input  logic [4:0]  fpu_reg,
  input  logic [31:0] fpu_data,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic        mem_fmode,
  input  logic [4:0]  mem_reg,
  input  logic [31:0] mem_data,
  output logic        wenable,
  output logic        wfmode,
  output logic [4:0]  wreg,
  output logic [31:0] wdata,
  input  logic        chk_fmode,
  input  logic [4:0]  chk_reg,
  output logic        chk_pending,
  output logic        idle
);
  localparam int AW  = $clog2(DEPTH);
  localparam int PW  = AW + 1;
  localparam int EW  = 38;  // {fmode, reg[4:0], data[31:0]}
  localparam int NS  = 3;
  localparam int ALU = 0;
  localparam int FPU = 1;
  localparam int MEM = 2;

  logic [NS-1:0]          in_valid;
  logic [NS-1:0][EW-1:0]  in_entry;
  logic [EW-1:0]          fifo_q [NS][DEPTH];
  logic [NS-1:0][PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count;
  logic [NS-1:0][3:0]     wait_q, wait_d;
  logic [NS-1:0]          nonempty, full, push, urgent, cand, grant;
  logic [EW-1:0]          sel;
  logic                   wenable_q, wenable_d, wfmode_q, wfmode_d;
  logic [4:0]             wreg_q, wreg_d;
  logic [31:0]            wdata_q, wdata_d;
  logic                   hit;
  logic [PW-1:0]          idx;

  assign in_valid      = {mem_valid, fpu_valid, alu_valid};
  assign in_entry[ALU] = {alu_fmode, alu_reg, alu_data};
  assign in_entry[FPU] = {fpu_fmode, fpu_reg, fpu_data};
  assign in_entry[MEM] = {mem_fmode, mem_reg, mem_data};

  // Occupancy comes from registered pointers only, so ready never reflects
  // a same-cycle pop.
  always_comb begin
    for (int s = 0; s < NS; s++) begin
      count[s]    = wr_ptr_q[s] - rd_ptr_q[s];
      nonempty[s] = (count[s] != '0);
      full[s]     = (count[s] == PW'(DEPTH));
      push[s]     = in_valid[s] & ~full[s];
    end
  end

  assign alu_ready = ~full[ALU];
  assign fpu_ready = ~full[FPU];
  assign mem_ready = ~full[MEM];

  // Urgent sources form the candidate set when any exist; otherwise every
  // non-empty source competes. Fixed priority then picks one.
  always_comb begin
    urgent = '0;
    grant  = '0;
    for (int s = 0; s < NS; s++)
      urgent[s] = nonempty[s] && (wait_q[s] >= 4'(STARVE_LIMIT));
    cand = (|urgent) ? urgent : nonempty;
    if (cand[MEM])      grant[MEM] = 1'b1;
    else if (cand[FPU]) grant[FPU] = 1'b1;
    else if (cand[ALU]) grant[ALU] = 1'b1;
  end

  always_comb begin
    sel = '0;
    for (int s = 0; s < NS; s++)
      if (grant[s]) sel = fifo_q[s][rd_ptr_q[s][AW-1:0]];
  end

  always_comb begin
    for (int s = 0; s < NS; s++) begin
      wr_ptr_d[s] = wr_ptr_q[s] + PW'(push[s]);
      rd_ptr_d[s] = rd_ptr_q[s] + PW'(grant[s]);
      if (grant[s] || !nonempty[s]) wait_d[s] = 4'd0;
      else if (wait_q[s] == 4'd15)  wait_d[s] = 4'd15;
      else                          wait_d[s] = wait_q[s] + 4'd1;
    end
  end

  // Integer x0 is popped like any entry but never strobes the write port.
  always_comb begin
    wenable_d = 1'b0;
    wfmode_d  = wfmode_q;
    wreg_d    = wreg_q;
    wdata_d   = wdata_q;
    if (|grant) begin
      wenable_d                    = sel[EW-1] | (|sel[EW-2:32]);
      {wfmode_d, wreg_d, wdata_d}  = sel;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      wait_q    <= '0;
      wenable_q <= 1'b0;
      wfmode_q  <= 1'b0;
      wreg_q    <= '0;
      wdata_q   <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      wait_q    <= wait_d;
      wenable_q <= wenable_d;
      wfmode_q  <= wfmode_d;
      wreg_q    <= wreg_d;
      wdata_q   <= wdata_d;
    end
  end

  // FIFO storage: validity is tracked by the pointers, so no reset needed.
  always_ff @(posedge clk) begin
    for (int s = 0; s < NS; s++)
      if (push[s]) fifo_q[s][wr_ptr_q[s][AW-1:0]] <= in_entry[s];
  end

  // Walk each FIFO from its head; only the first count[s] slots are live.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int s = 0; s < NS; s++) begin
      for (int k = 0; k < DEPTH; k++) begin
        idx = rd_ptr_q[s] + PW'(k);
        if ((PW'(k) < count[s]) &&
            (fifo_q[s][idx[AW-1:0]][EW-1:32] == {chk_fmode, chk_reg}))
          hit = 1'b1;
      end
    end
    if (wenable_q && ({wfmode_q, wreg_q} == {chk_fmode, chk_reg})) hit = 1'b1;
    if (!chk_fmode && (chk_reg == 5'd0)) hit = 1'b0;
  end

  assign chk_pending = hit;
  assign wenable     = wenable_q;
  assign wfmode      = wfmode_q;
  assign wreg        = wreg_q;
  assign wdata       = wdata_q;
  assign idle        = ~(|nonempty) & ~wenable_q;

endmodule
